// File: rtl/hilo_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_mul_unit
//  Description : Execute-stage HI/LO register owner. Runs mult/madd/msub/mul
//                on an iterative shift-add multiplier, performs mthi/mtlo and
//                the mfhi/mflo reads, and stalls the pipeline while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALUCtl,
    input  logic             HiLoWrite,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] ReadData,
    output logic [WIDTH-1:0] MulLow,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int       c_CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [4:0] c_OP_MULT = 5'b00101;
    localparam logic [4:0] c_OP_MADD = 5'b01100;
    localparam logic [4:0] c_OP_MSUB = 5'b01101;
    localparam logic [4:0] c_OP_MUL  = 5'b11000;
    localparam logic [4:0] c_OP_MTHI = 5'b10001;
    localparam logic [4:0] c_OP_MTLO = 5'b10011;
    localparam logic [4:0] c_OP_MFHI = 5'b10000;
    localparam logic [4:0] c_OP_MFLO = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_mullow;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_sign;
    logic [4:0]           r_op;

    logic                 w_is_mulop;
    logic                 w_is_mfhi;
    logic                 w_is_mflo;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;

    assign w_is_mulop = (ALUCtl == c_OP_MULT) || (ALUCtl == c_OP_MADD) ||
                        (ALUCtl == c_OP_MSUB) || (ALUCtl == c_OP_MUL);
    assign w_is_mfhi  = (ALUCtl == c_OP_MFHI);
    assign w_is_mflo  = (ALUCtl == c_OP_MFLO);
    assign w_accept   = (r_state == S_IDLE) && Start && HiLoWrite && w_is_mulop;
    assign w_last     = (r_cnt == c_CW'(WIDTH - 1));

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude.
    assign w_abs_a = A[WIDTH-1] ? (-A) : A;
    assign w_abs_b = B[WIDTH-1] ? (-B) : B;

    // Extra carry bit keeps the upper-half add exact before the right shift.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                    {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_prod = r_sign ? (-r_acc) : r_acc;

    assign Hi     = r_hi;
    assign Lo     = r_lo;
    assign MulLow = r_mullow;
    assign Stall  = Busy && Start && (HiLoWrite || w_is_mfhi || w_is_mflo);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        Busy        = (r_state != S_IDLE);
        Done        = (r_state == S_FIN);
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
            S_MUL:   if (w_last)   w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // mfhi/mflo read port; any other code reads zero.
    always_comb begin
        ReadData = '0;
        if (w_is_mfhi) begin
            ReadData = r_hi;
        end else if (w_is_mflo) begin
            ReadData = r_lo;
        end
    end

    // Datapath: operand capture, shift-add steps, HI/LO and MulLow commits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_mullow <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_op     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_op     <= ALUCtl;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (Start && HiLoWrite && (ALUCtl == c_OP_MTHI)) begin
                        r_hi <= A;
                    end else if (Start && HiLoWrite && (ALUCtl == c_OP_MTLO)) begin
                        r_lo <= A;
                    end
                end
                S_MUL: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CW'(1);
                end
                S_FIN: begin
                    case (r_op)
                        c_OP_MULT: {r_hi, r_lo} <= w_prod;
                        c_OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                        c_OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
                        c_OP_MUL:  r_mullow     <= w_prod[WIDTH-1:0];
                        default:   r_mullow     <= r_mullow;
                    endcase
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_mul_unit
//  Description : Directed self-checking bench for hilo_mul_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_mul_unit;

    localparam int c_W = 32;
    localparam logic [4:0] c_MULT = 5'b00101;
    localparam logic [4:0] c_MADD = 5'b01100;
    localparam logic [4:0] c_MSUB = 5'b01101;
    localparam logic [4:0] c_MUL  = 5'b11000;
    localparam logic [4:0] c_MTHI = 5'b10001;
    localparam logic [4:0] c_MTLO = 5'b10011;
    localparam logic [4:0] c_MFHI = 5'b10000;
    localparam logic [4:0] c_MFLO = 5'b10010;
    localparam logic [4:0] c_ADD  = 5'b00010;

    logic           Clk = 1'b0;
    logic           Reset, Start, HiLoWrite;
    logic [4:0]     ALUCtl;
    logic [c_W-1:0] A, B;
    logic [c_W-1:0] Hi, Lo, ReadData, MulLow;
    logic           Busy, Done, Stall;

    int total = 0;
    int bad   = 0;

    hilo_mul_unit #(.WIDTH(c_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtl(ALUCtl),
        .HiLoWrite(HiLoWrite), .A(A), .B(B), .Hi(Hi), .Lo(Lo),
        .ReadData(ReadData), .MulLow(MulLow), .Busy(Busy), .Done(Done),
        .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    // Issue a multiply-class op and follow it until Busy drops (bounded).
    task automatic run_mul(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int nbusy,
                           output int ndone, output int done_at);
        @(negedge Clk);
        Start = 1'b1; HiLoWrite = 1'b1; ALUCtl = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; HiLoWrite = 1'b0; ALUCtl = c_ADD;
        nbusy = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 100; i++) begin
            if (!Busy) break;
            nbusy++;
            if (Done) begin
                ndone++;
                done_at = nbusy;
            end
            @(negedge Clk);
        end
    endtask

    // Single-cycle op; returns at the negedge after the accepting edge.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a);
        @(negedge Clk);
        Start = 1'b1; HiLoWrite = 1'b1; ALUCtl = op; A = a; B = '0;
        @(negedge Clk);
        Start = 1'b0; HiLoWrite = 1'b0; ALUCtl = c_ADD;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        ALUCtl = c_MFHI;
        #1;
        total++; if (Hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        total++; if (Lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        total++; if (MulLow !== 32'h0) begin bad++; $display("FAIL reset_mullow got=%h exp=0", MulLow); end
        total++; if ({Busy, Done, Stall} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {Busy, Done, Stall}); end
        total++; if (ReadData !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", ReadData); end
        // Unknown code with Start/HiLoWrite must not start anything.
        @(negedge Clk);
        Start = 1'b1; HiLoWrite = 1'b1; ALUCtl = 5'b00111; A = 32'd3; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0; HiLoWrite = 1'b0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL bad_code_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_mult;
        int nb, nd, da;
        run_mul(c_MULT, 32'hFFFF_FFFD, 32'd7, nb, nd, da);
        total++; if (nb !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", nb); end
        total++; if (nd !== 1 || da !== 33) begin bad++; $display("FAIL mult_done got=%0d@%0d exp=1@33", nd, da); end
        total++; if (Hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", Hi); end
        total++; if (Lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", Lo); end
    endtask

    task automatic test_madd_msub;
        int nb, nd, da;
        do_op(c_MTHI, 32'h0);
        do_op(c_MTLO, 32'h10);
        total++; if (Lo !== 32'h10) begin bad++; $display("FAIL mtlo got=%h exp=10", Lo); end
        run_mul(c_MADD, 32'd4, 32'd5, nb, nd, da);
        total++; if ({Hi, Lo} !== 64'h24) begin bad++; $display("FAIL madd got=%h exp=24", {Hi, Lo}); end
        run_mul(c_MSUB, 32'h24, 32'd1, nb, nd, da);
        total++; if ({Hi, Lo} !== 64'h0) begin bad++; $display("FAIL msub got=%h exp=0", {Hi, Lo}); end
    endtask

    task automatic test_wrap;
        int nb, nd, da;
        run_mul(c_MSUB, 32'd1, 32'd1, nb, nd, da);
        total++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL msub_wrap got=%h exp=all ones", {Hi, Lo}); end
        run_mul(c_MULT, 32'h8000_0000, 32'h8000_0000, nb, nd, da);
        total++; if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mult_minmin got=%h exp=4000000000000000", {Hi, Lo}); end
    endtask

    task automatic test_mul;
        int nb, nd, da;
        run_mul(c_MUL, 32'h1234_5678, 32'h10, nb, nd, da);
        total++; if (MulLow !== 32'h2345_6780) begin bad++; $display("FAIL mul_low got=%h exp=23456780", MulLow); end
        total++; if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mul_hilo_kept got=%h exp=4000000000000000", {Hi, Lo}); end
    endtask

    task automatic test_stall;
        int waited;
        @(negedge Clk);
        Start = 1'b1; HiLoWrite = 1'b1; ALUCtl = c_MULT; A = 32'd2; B = 32'd3;
        @(negedge Clk);
        HiLoWrite = 1'b0; ALUCtl = c_MFLO;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL stall_mflo got=%b exp=1", Stall); end
        @(negedge Clk);
        HiLoWrite = 1'b1; ALUCtl = c_MTHI; A = 32'hAA;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL stall_mthi got=%b exp=1", Stall); end
        @(negedge Clk);
        total++; if (Hi !== 32'h4000_0000) begin bad++; $display("FAIL busy_mthi_blocked got=%h exp=40000000", Hi); end
        HiLoWrite = 1'b0; ALUCtl = c_ADD;
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL no_stall_add got=%b exp=0", Stall); end
        @(negedge Clk);
        Start = 1'b0;
        waited = 0;
        while (Busy && waited < 60) begin
            @(negedge Clk);
            waited++;
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL stall_mult_timeout busy=%b exp=0", Busy); end
        total++; if ({Hi, Lo} !== 64'h6) begin bad++; $display("FAIL stall_mult_result got=%h exp=6", {Hi, Lo}); end
        do_op(c_MTHI, 32'hAA);
        ALUCtl = c_MFHI;
        #1;
        total++; if (ReadData !== 32'hAA) begin bad++; $display("FAIL mfhi_after_mthi got=%h exp=aa", ReadData); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
        ALUCtl = c_MFLO;
        #1;
        total++; if (ReadData !== 32'h6) begin bad++; $display("FAIL mflo_read got=%h exp=6", ReadData); end
        ALUCtl = c_ADD;
    endtask

    task automatic test_reset_mid;
        int nb, nd, da;
        @(negedge Clk);
        Start = 1'b1; HiLoWrite = 1'b1; ALUCtl = c_MULT; A = 32'd7; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0; HiLoWrite = 1'b0; ALUCtl = c_ADD;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        total++; if ({Busy, Done} !== 2'b00) begin bad++; $display("FAIL midreset_status got=%b exp=00", {Busy, Done}); end
        total++; if ({Hi, Lo, MulLow} !== 96'h0) begin bad++; $display("FAIL midreset_regs got=%h exp=0", {Hi, Lo, MulLow}); end
        run_mul(c_MULT, 32'd5, 32'd6, nb, nd, da);
        total++; if (nb !== 33 || nd !== 1) begin bad++; $display("FAIL postreset_mult_timing got=%0d/%0d exp=33/1", nb, nd); end
        total++; if ({Hi, Lo} !== 64'h1E) begin bad++; $display("FAIL postreset_mult got=%h exp=1e", {Hi, Lo}); end
    endtask

    task automatic test_back_to_back;
        int nb, nd, da;
        run_mul(c_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd, da);
        run_mul(c_MADD, 32'hFFFF_FFFE, 32'd3, nb, nd, da);
        total++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFB) begin bad++; $display("FAIL b2b_madd got=%h exp=fffffffffffffffb", {Hi, Lo}); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; HiLoWrite = 1'b0; ALUCtl = c_ADD;
        A = '0; B = '0;
        test_reset;
        test_mult;
        test_madd_msub;
        test_wrap;
        test_mul;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_mul_unit.md
Name: hilo_mul_unit

Overview:
- Execute-stage consumer of the ALU-control outputs `ALUCtl` and `HiLoWrite`. It owns the HI/LO architectural registers.
- Executes the HI/LO-class operations: mult, madd, msub, mul, mthi, mtlo, mfhi, mflo.
- Multiplies iteratively over multiple cycles and asserts `Stall` to hold the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; the product is 2*WIDTH bits.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  valid EX-stage instruction presented this cycle.
- ALUCtl  input  5  operation code from ALU control.
- HiLoWrite  input  1  operation targets HI/LO.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Hi  output  WIDTH  current HI register.
- Lo  output  WIDTH  current LO register.
- ReadData  output  WIDTH  mfhi/mflo read value.
- MulLow  output  WIDTH  low word of the last mul result (for rd writeback).
- Busy  output  1  multiply in progress.
- Done  output  1  one-cycle pulse in the final multiply cycle.
- Stall  output  1  pipeline must hold the EX instruction.

Behaviour:
- Operation codes:
  - 00101 mult
  - 01100 madd
  - 01101 msub
  - 11000 mul
  - 10001 mthi
  - 10011 mtlo
  - 10000 mfhi
  - 10010 mflo
  - Any other code causes no action and no Stall.
- All multiplies are signed two's-complement.
- Reset (any state, including mid-multiply): return to IDLE; Hi=Lo=0; MulLow=0; internal accumulator, counter and operand registers cleared; Busy=Done=0. Any in-flight result is discarded.
- States: IDLE, MUL, FIN.
  - Busy = (state != IDLE).
  - Done = (state == FIN).
- IDLE, accept condition: Start & HiLoWrite & code in {mult, madd, msub, mul}.
  - Latch |A|, |B|, result sign = A[W-1]^B[W-1], and the op.
  - Clear the product accumulator and set the counter to 0.
  - Next state MUL.
- MUL: one shift-add step per cycle (test multiplier LSB, add multiplicand into the upper half, shift right).
  - Counter increments; after WIDTH cycles (counter == WIDTH-1) go to FIN.
- FIN: apply sign (two's-complement negate of the 2*WIDTH product if sign=1), then at the closing edge commit:
  - mult: {Hi,Lo} = P.
  - madd: {Hi,Lo} = {Hi,Lo} + P, modulo 2^(2*WIDTH).
  - msub: {Hi,Lo} = {Hi,Lo} - P, modulo 2^(2*WIDTH).
  - mul: MulLow = P[W-1:0]; Hi/Lo unchanged.
  - Next state IDLE.
- Latency: accept at edge k gives Busy=1 on cycles k+1 .. k+WIDTH+1; Done=1 in cycle k+WIDTH+1; Hi/Lo/MulLow reflect the result from cycle k+WIDTH+2.
- mthi/mtlo in IDLE with Start: Hi (resp. Lo) = A at that edge; single cycle, Busy stays 0.
- mfhi/mflo: ReadData = Hi or Lo combinationally from the current register. It returns 0 for any other code.
  - No bypass of a same-cycle mthi/mtlo write: the value is visible the cycle after the write.
- Stall = Busy & Start & (HiLoWrite | code is mfhi | code is mflo).
  - While Busy, Start is never accepted and Hi/Lo are not modified by mthi/mtlo.
  - The pipeline re-presents the instruction; it is accepted in the first cycle with Busy=0. The cycle after FIN is IDLE, so back-to-back multiplies have one free cycle between them.
- Start with a non-HI/LO code while Busy: no Stall (independent ALU ops proceed).
- Start=0: no state change except multiply progress.
- Outputs Hi, Lo, MulLow are registers. ReadData, Busy, Done and Stall are decoded from registers and inputs only (no latches).

Test Plan:
- Reset, then mult A=0xFFFFFFFD (-3), B=7 -> Busy high 33 cycles, Done pulse on the 33rd; then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- mthi A=0, mtlo A=0x10, then madd A=4, B=5 -> Lo=0x24, Hi=0. Then msub A=0x24, B=1 -> Hi=Lo=0.
- Hi=Lo=0, msub A=1, B=1 -> Hi=Lo=0xFFFFFFFF (wrap). mult A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- mul A=0x12345678, B=0x10 -> MulLow=0x23456780; Hi/Lo retain their prior values.
- During a mult: present mflo, then mthi A=0xAA -> Stall=1 each cycle and Hi unchanged. After completion, mthi is accepted and mfhi returns 0xAA the next cycle. An add (non-HI/LO code) while Busy -> Stall=0.
- Start mult, assert Reset in MUL cycle 10 -> next cycle Busy=0, Done never pulses, Hi=Lo=MulLow=0. A new mult is accepted immediately after.
